mac_seq_ctrl: RTL and testbench

- Tile sequencer for the ROW x COLUMN systolic MAC array.
- Per tile, it buffers one full weight set from the weight fetch stream and issues it into the array as a gap-free ROW-cycle burst.
- It then forwards a framed activation stream (first/last/valid/ready) into the array and waits for that tile's last result beat before starting the next tile.
- It sits between the weight/activation fetch units and the MAC array; the result stream bypasses it, and it only snoops the array output handshake.

---
 rtl/mac_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// Tile sequencer for a ROW x COLUMN systolic MAC array: buffers a weight set, issues it,
// streams framed activations, then waits for the tile's last result. Optional: MAC_SEQ_CTRL_PERF_EN.
module mac_seq_ctrl #(
    parameter int DW     = 8,
    parameter int WW     = 8,
    parameter int CW     = 19,
    parameter int ROW    = 8,
    parameter int COLUMN = 6,
    parameter int LW     = 16,
    parameter int TW     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LW-1:0]          cfg_len,
    input  logic [TW-1:0]          cfg_tiles,
    output logic                   busy,
    output logic                   done,
    input  logic [COLUMN*WW-1:0]   wt_data,
    input  logic                   wt_valid,
    output logic                   wt_ready,
    input  logic [ROW*DW-1:0]      act_data,
    input  logic                   act_valid,
    output logic                   act_ready,
    output logic [COLUMN*WW-1:0]   mac_w,
    output logic [COLUMN-1:0]      mac_w_en,
    output logic [COLUMN*CW-1:0]   mac_ci,
    output logic [ROW*DW-1:0]      mac_m_data,
    output logic                   mac_m_first,
    output logic                   mac_m_last,
    output logic                   mac_m_valid,
    input  logic                   mac_m_ready,
    input  logic                   mac_s_valid,
    input  logic                   mac_s_last,
    input  logic                   mac_s_ready
`ifdef MAC_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]            perf_busy,
    output logic [31:0]            perf_stall
`endif
);

    localparam int CNTW = $clog2(ROW + 1);
    localparam int AW   = $clog2(ROW);

    typedef enum logic [2:0] {
        S_IDLE, S_WFILL, S_WISSUE, S_WSETTLE, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t state, next_state;

    logic [COLUMN*WW-1:0] wbuf [ROW];
    logic [CNTW-1:0]      cnt;
    logic [LW-1:0]        bcnt;
    logic [LW-1:0]        len_q;
    logic [TW-1:0]        tile_cnt;
    logic [TW-1:0]        tiles_q;
    logic [COLUMN*WW-1:0] mac_w_q;
    logic [COLUMN-1:0]    mac_w_en_q;

    logic start_ok, cfg_zero, wt_fire, act_fire, s_last_fire;
    logic cnt_last, bcnt_last, tile_last;
    logic [AW-1:0] rd_idx;

    assign start_ok    = (state == S_IDLE) && start;
    assign cfg_zero    = (cfg_len == '0) || (cfg_tiles == '0);
    assign wt_fire     = (state == S_WFILL) && wt_valid;
    assign act_fire    = (state == S_STREAM) && act_valid && mac_m_ready;
    assign s_last_fire = (state == S_DRAIN) && mac_s_valid && mac_s_ready && mac_s_last;
    assign cnt_last    = (cnt == CNTW'(ROW - 1));
    assign bcnt_last   = (bcnt == len_q - LW'(1));
    assign tile_last   = (tile_cnt == tiles_q - TW'(1));
    // Issue runs deepest row first; slot ROW-1 was loaded straight from wt_data on entry.
    assign rd_idx      = AW'(ROW - 2) - cnt[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        busy        = (state != S_IDLE);
        done        = 1'b0;
        wt_ready    = 1'b0;
        act_ready   = 1'b0;
        mac_m_valid = 1'b0;
        mac_m_data  = '0;
        mac_m_first = 1'b0;
        mac_m_last  = 1'b0;
        case (state)
            S_IDLE:    if (start) next_state = cfg_zero ? S_DONE : S_WFILL;
            S_WFILL: begin
                wt_ready = 1'b1;
                if (wt_valid && cnt_last) next_state = S_WISSUE;
            end
            S_WISSUE:  if (cnt_last) next_state = S_WSETTLE;
            S_WSETTLE: if (cnt_last) next_state = S_STREAM;
            S_STREAM: begin
                mac_m_valid = act_valid;
                act_ready   = mac_m_ready;
                mac_m_data  = act_data;
                mac_m_first = (bcnt == '0);
                mac_m_last  = bcnt_last;
                if (act_fire && bcnt_last) next_state = S_DRAIN;
            end
            S_DRAIN:   if (s_last_fire) next_state = tile_last ? S_DONE : S_WFILL;
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wt_fire) wbuf[cnt[AW-1:0]] <= wt_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            bcnt       <= '0;
            len_q      <= '0;
            tile_cnt   <= '0;
            tiles_q    <= '0;
            mac_w_q    <= '0;
            mac_w_en_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_ok) begin
                    len_q    <= cfg_len;
                    tiles_q  <= cfg_tiles;
                    tile_cnt <= '0;
                    bcnt     <= '0;
                    cnt      <= '0;
                end
                S_WFILL: if (wt_fire) begin
                    if (cnt_last) begin
                        cnt        <= '0;
                        mac_w_q    <= wt_data;
                        mac_w_en_q <= '1;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                S_WISSUE: begin
                    if (cnt_last) begin
                        cnt        <= '0;
                        mac_w_en_q <= '0;
                    end else begin
                        cnt     <= cnt + CNTW'(1);
                        mac_w_q <= wbuf[rd_idx];
                    end
                end
                S_WSETTLE: cnt <= cnt_last ? '0 : cnt + CNTW'(1);
                S_STREAM: if (act_fire) bcnt <= bcnt_last ? '0 : bcnt + LW'(1);
                S_DRAIN: if (s_last_fire && !tile_last) tile_cnt <= tile_cnt + TW'(1);
                default: ;
            endcase
        end
    end

    assign mac_w    = mac_w_q;
    assign mac_w_en = mac_w_en_q;
    assign mac_ci   = '0;

`ifdef MAC_SEQ_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (busy && (perf_busy != '1)) perf_busy <= perf_busy + 32'd1;
            if ((state == S_STREAM) && act_valid && !mac_m_ready && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: weight fill/issue order, framed streaming with stalls,
// multi-tile jobs, zero-length jobs and mid-stream reset, with hand-computed expectations.
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_len;
    logic [7:0]  cfg_tiles;
    logic        busy, done;
    logic [47:0] wt_data;
    logic        wt_valid, wt_ready;
    logic [63:0] act_data;
    logic        act_valid, act_ready;
    logic [47:0] mac_w;
    logic [5:0]  mac_w_en;
    logic [113:0] mac_ci;
    logic [63:0] mac_m_data;
    logic        mac_m_first, mac_m_last, mac_m_valid, mac_m_ready;
    logic        mac_s_valid, mac_s_last, mac_s_ready;
`ifdef MAC_SEQ_CTRL_PERF_EN
    logic [31:0] perf_busy, perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_tiles(cfg_tiles),
        .busy(busy), .done(done),
        .wt_data(wt_data), .wt_valid(wt_valid), .wt_ready(wt_ready),
        .act_data(act_data), .act_valid(act_valid), .act_ready(act_ready),
        .mac_w(mac_w), .mac_w_en(mac_w_en), .mac_ci(mac_ci),
        .mac_m_data(mac_m_data), .mac_m_first(mac_m_first), .mac_m_last(mac_m_last),
        .mac_m_valid(mac_m_valid), .mac_m_ready(mac_m_ready),
        .mac_s_valid(mac_s_valid), .mac_s_last(mac_s_last), .mac_s_ready(mac_s_ready)
`ifdef MAC_SEQ_CTRL_PERF_EN
        , .perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] wvec(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {6{b}};
    endfunction

    function automatic logic [63:0] avec(input int tid, input int b);
        logic [7:0] v;
        v = 8'(b * 16 + tid + 1);
        return {8{v}};
    endfunction

    task automatic start_job(input int len, input int tiles);
        start = 1'b1; cfg_len = 16'(len); cfg_tiles = 8'(tiles);
        settle;
        chk("idle_busy", busy, 1'b0);
        tick;
        start = 1'b0;
        settle;
        chk("wfill_busy", busy, 1'b1);
        chk("wfill_ready", wt_ready, 1'b1);
    endtask

    // Vector k carries byte k in every column; gaps insert an idle cycle after beats 1..7.
    task automatic fill(input bit gaps);
        for (int i = 1; i <= 8; i++) begin
            wt_valid = 1'b1; wt_data = wvec(i);
            settle;
            chk("fill_ready", wt_ready, 1'b1);
            chk("fill_w_en", mac_w_en, 6'h00);
            tick;
            if (gaps && i < 8) begin
                wt_valid = 1'b0; wt_data = 48'hDEAD_BEEF_0000;
                settle;
                chk("gap_ready", wt_ready, 1'b1);
                tick;
            end
        end
        wt_valid = 1'b0;
    endtask

    task automatic issue;
        for (int k = 0; k < 8; k++) begin
            settle;
            chk("issue_en", mac_w_en, 6'h3F);
            chk("issue_w", mac_w, wvec(8 - k));
            chk("issue_wt_ready", wt_ready, 1'b0);
            tick;
        end
        for (int s = 0; s < 8; s++) begin
            settle;
            chk("settle_en", mac_w_en, 6'h00);
            chk("settle_w", mac_w, wvec(1));
            chk("settle_act_ready", act_ready, 1'b0);
            tick;
        end
    endtask

    task automatic stream(input int len, input int tid, input int stall_at, input int stall_n);
        for (int b = 0; b < len; b++) begin
            act_valid = 1'b1; act_data = avec(tid, b);
            if (b == stall_at) begin
                mac_m_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    settle;
                    chk("stall_act_ready", act_ready, 1'b0);
                    chk("stall_valid", mac_m_valid, 1'b1);
                    chk("stall_first", mac_m_first, b == 0);
                    chk("stall_last", mac_m_last, b == len - 1);
                    tick;
                end
            end
            mac_m_ready = 1'b1;
            settle;
            chk("beat_act_ready", act_ready, 1'b1);
            chk("beat_valid", mac_m_valid, 1'b1);
            chk("beat_data", mac_m_data, avec(tid, b));
            chk("beat_first", mac_m_first, b == 0);
            chk("beat_last", mac_m_last, b == len - 1);
            tick;
        end
        settle;
        chk("drain_act_ready", act_ready, 1'b0);
        chk("drain_valid", mac_m_valid, 1'b0);
        act_valid = 1'b0;
    endtask

    task automatic drain(input bit final_tile);
        mac_s_valid = 1'b1; mac_s_ready = 1'b1; mac_s_last = 1'b0;
        tick;
        settle;
        chk("drain_nonlast_done", done, 1'b0);
        chk("drain_nonlast_busy", busy, 1'b1);
        mac_s_last = 1'b1;
        tick;
        mac_s_valid = 1'b0; mac_s_ready = 1'b0; mac_s_last = 1'b0;
        settle;
        if (final_tile) begin
            chk("done_pulse", done, 1'b1);
            chk("done_wt_ready", wt_ready, 1'b0);
            tick;
            settle;
            chk("done_clear", done, 1'b0);
            chk("idle_busy", busy, 1'b0);
        end else begin
            chk("next_tile_done", done, 1'b0);
            chk("next_tile_wfill", wt_ready, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_tiles = '0;
        wt_data = '0; wt_valid = 1'b0; act_data = '0; act_valid = 1'b0;
        mac_m_ready = 1'b1; mac_s_valid = 1'b0; mac_s_last = 1'b0; mac_s_ready = 1'b0;
        repeat (3) tick;
        settle;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wt_ready", wt_ready, 1'b0);
        chk("rst_act_ready", act_ready, 1'b0);
        chk("rst_w_en", mac_w_en, 6'h00);
        chk("rst_w", mac_w, 48'h0);
        chk("rst_ci", mac_ci, 114'h0);
        chk("rst_m_valid", mac_m_valid, 1'b0);
        rst = 1'b0;
        tick;

        // Single tile, len 4
        start_job(4, 1);
        fill(1'b0);
        issue;
        stream(4, 0, -1, 0);
        drain(1'b1);

        // Gappy weight fill; output-last beats outside DRAIN must be ignored
        mac_s_valid = 1'b1; mac_s_ready = 1'b1; mac_s_last = 1'b1;
        start_job(2, 1);
        fill(1'b1);
        mac_s_valid = 1'b0; mac_s_ready = 1'b0; mac_s_last = 1'b0;
        issue;
        stream(2, 1, -1, 0);
        drain(1'b1);

        // 5-cycle stall on beat 2 of 6; a start with new cfg mid-job is ignored
        start_job(6, 1);
        fill(1'b0);
        start = 1'b1; cfg_len = 16'd1; cfg_tiles = 8'd5;
        issue;
        start = 1'b0;
        stream(6, 2, 2, 5);
        drain(1'b1);
`ifdef MAC_SEQ_CTRL_PERF_EN
        chk("perf_stall", perf_stall, 32'd5);
        chk("perf_busy", perf_busy, 32'd38);
`endif

        // Three tiles of one beat each
        start_job(1, 3);
        for (int t = 0; t < 3; t++) begin
            fill(1'b0);
            issue;
            stream(1, t, -1, 0);
            drain(t == 2);
        end

        // Zero-length jobs finish immediately with no traffic
        for (int z = 0; z < 2; z++) begin
            start = 1'b1;
            cfg_len = (z == 0) ? 16'd0 : 16'd5;
            cfg_tiles = (z == 0) ? 8'd2 : 8'd0;
            act_valid = 1'b1; wt_valid = 1'b1;
            tick;
            start = 1'b0;
            settle;
            chk("zero_done", done, 1'b1);
            chk("zero_wt_ready", wt_ready, 1'b0);
            chk("zero_act_ready", act_ready, 1'b0);
            tick;
            settle;
            chk("zero_done_clear", done, 1'b0);
            chk("zero_idle", busy, 1'b0);
            act_valid = 1'b0; wt_valid = 1'b0;
        end

        // Reset in the middle of STREAM
        start_job(4, 1);
        fill(1'b0);
        issue;
        act_valid = 1'b1; mac_m_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            act_data = avec(7, b);
            tick;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        settle;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_act_ready", act_ready, 1'b0);
        chk("abort_m_valid", mac_m_valid, 1'b0);
        chk("abort_m_first", mac_m_first, 1'b0);
        chk("abort_m_data", mac_m_data, 64'h0);
        chk("abort_w", mac_w, 48'h0);
        chk("abort_w_en", mac_w_en, 6'h00);
        chk("abort_wt_ready", wt_ready, 1'b0);
        act_valid = 1'b0;
        tick;
        settle;
        chk("abort_no_done", done, 1'b0);
        chk("abort_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
